// File: rtl/stack_seq_pkg.sv
// Shared opcodes, error codes and state encoding for the stack program sequencer.
// Used by stack_prog_sequencer and stack_seq_mem.
package stack_seq_pkg;

    localparam logic [3:0] OP_INC  = 4'd0;
    localparam logic [3:0] OP_DEC  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_POP2 = 4'd5;
    localparam logic [3:0] OP_MOD  = 4'd6;
    localparam logic [3:0] OP_PUSH = 4'd7;
    localparam logic [3:0] OP_POP  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_STACK   = 2'd2;
    localparam logic [1:0] ERR_EMPTY   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_CHECK,
        S_HOLD
    } state_e;

endpackage

// File: rtl/stack_seq_mem.sv
// Program RAM: synchronous write, registered read of {opcode, immediate}.
// Contents are intentionally not reset.
module stack_seq_mem
    import stack_seq_pkg::*;
#(
    parameter int W   = 16,
    parameter int AW  = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [OPW-1:0] wop,
    input  logic [W-1:0]   wimm,
    input  logic [AW-1:0]  raddr,
    output logic [OPW-1:0] rop,
    output logic [W-1:0]   rimm
);

    logic [OPW+W-1:0] ram [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= {wop, wimm};
        end
        {rop, rimm} <= ram[raddr];
    end

endmodule

// File: rtl/stack_prog_sequencer.sv
// Microprogram sequencer issuing one stack-unit op per instruction.
// Optional single-step gating via STACK_SEQ_STEP_EN (adds input step).
module stack_prog_sequencer
    import stack_seq_pkg::*;
#(
    parameter int W   = 16,
    parameter int AW  = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
`ifdef STACK_SEQ_STEP_EN
    input  logic           step,
`endif
    input  logic           prog_we,
    input  logic [AW-1:0]  prog_addr,
    input  logic [OPW-1:0] prog_op,
    input  logic [W-1:0]   prog_imm,
    output logic [OPW-1:0] stk_op,
    output logic [W-1:0]   stk_in,
    output logic           stk_apply,
    input  logic [W-1:0]   stk_head,
    input  logic           stk_empty,
    input  logic           stk_valid,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [1:0]     err_code,
    output logic [AW-1:0]  pc,
    output logic [W-1:0]   result
);

    localparam logic [AW-1:0]  PC_LAST = {AW{1'b1}};
    localparam logic [OPW-1:0] HALT    = OPW'(OP_HALT);
    localparam logic [OPW-1:0] LAST_OK = OPW'(OP_POP);

    state_e         state;
    logic           apply_q;
    logic           go;
    logic [OPW-1:0] mem_op;
    logic [W-1:0]   mem_imm;
    logic           halt_ok;
    logic           halt_bad;
    logic           op_bad;

`ifdef STACK_SEQ_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    stack_seq_mem #(.W(W), .AW(AW), .OPW(OPW)) u_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wop   (prog_op),
        .wimm  (prog_imm),
        .raddr (pc),
        .rop   (mem_op),
        .rimm  (mem_imm)
    );

    assign halt_ok   = (mem_op == HALT) && !stk_empty;
    assign halt_bad  = (mem_op == HALT) && stk_empty;
    assign op_bad    = (mem_op > LAST_OK) && (mem_op != HALT);
    // Abort must kill an in-flight issue strobe in the very cycle it is seen.
    assign stk_apply = apply_q && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            apply_q  <= 1'b0;
            stk_op   <= '0;
            stk_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            pc       <= '0;
            result   <= '0;
        end else if (abort && state != S_IDLE) begin
            state   <= S_IDLE;
            apply_q <= 1'b0;
            stk_op  <= '0;
            stk_in  <= '0;
            busy    <= 1'b0;
        end else begin
            apply_q <= 1'b0;
            stk_op  <= '0;
            stk_in  <= '0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state    <= go ? S_FETCH : S_HOLD;
                        pc       <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        busy     <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (go) state <= S_FETCH;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    unique case (1'b1)
                        halt_ok: begin
                            result <= stk_head;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end
                        halt_bad: begin
                            error    <= 1'b1;
                            err_code <= ERR_EMPTY;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                        op_bad: begin
                            error    <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                        default: begin
                            apply_q <= 1'b1;
                            stk_op  <= mem_op;
                            stk_in  <= mem_imm;
                            state   <= S_ISSUE;
                        end
                    endcase
                end
                S_ISSUE: state <= S_CHECK;
                S_CHECK: begin
                    if (!stk_valid) begin
                        error    <= 1'b1;
                        err_code <= ERR_STACK;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (pc == PC_LAST) begin
                        result <= stk_head;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= go ? S_FETCH : S_HOLD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_prog_sequencer.sv
// Bench for stack_prog_sequencer: stub stack unit plus program-level model.
// Directed programs with per-cycle comparison against the model.
`timescale 1ns/1ps
module tb_stack_prog_sequencer;
    import stack_seq_pkg::*;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int OPW = 4;
    localparam int D  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           step = 1'b1;
    logic           prog_we = 1'b0;
    logic [AW-1:0]  prog_addr = '0;
    logic [OPW-1:0] prog_op = '0;
    logic [W-1:0]   prog_imm = '0;
    logic [OPW-1:0] stk_op;
    logic [W-1:0]   stk_in;
    logic           stk_apply;
    logic [W-1:0]   stk_head = '0;
    logic           stk_empty = 1'b1;
    logic           stk_valid = 1'b1;
    logic           busy, done, error;
    logic [1:0]     err_code;
    logic [AW-1:0]  pc;
    logic [W-1:0]   result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stack_prog_sequencer #(.W(W), .AW(AW), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
`ifdef STACK_SEQ_STEP_EN
        .step      (step),
`endif
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_op   (prog_op),
        .prog_imm  (prog_imm),
        .stk_op    (stk_op),
        .stk_in    (stk_in),
        .stk_apply (stk_apply),
        .stk_head  (stk_head),
        .stk_empty (stk_empty),
        .stk_valid (stk_valid),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .pc        (pc),
        .result    (result)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Stack-unit semantics shared by the stub and the model
    function automatic int arity(input logic [3:0] op);
        case (op)
            OP_PUSH: return 0;
            OP_INC, OP_DEC, OP_POP: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic bit keeps(input logic [3:0] op);
        return !(op == OP_POP || op == OP_POP2);
    endfunction

    function automatic bit legal(input logic [3:0] op, input logic [W-1:0] b,
                                 input int sp);
        if (sp < arity(op)) return 1'b0;
        if (op == OP_MOD && b == '0) return 1'b0;
        if (op == OP_PUSH && sp == D) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] alu(input logic [3:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] imm);
        case (op)
            OP_INC:  return b + 1'b1;
            OP_DEC:  return b - 1'b1;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_MOD:  return a % b;
            OP_PUSH: return imm;
            default: return '0;
        endcase
    endfunction

    // Stub stack unit
    logic [W-1:0] ss [D];
    int           ssp = 0;
    bit           sbad = 1'b0;
    int           fail_at = 0;
    int           apply_cnt = 0;
    bit           clr_tog = 1'b0;
    bit           clr_seen = 1'b0;
    logic [W-1:0] sa, sb;

    always @(posedge clk) begin
        if (clr_tog != clr_seen) begin
            clr_seen = clr_tog;
            ssp = 0;
            sbad = 1'b0;
        end
        if (stk_apply) begin
            apply_cnt++;
            sb = (ssp > 0) ? ss[ssp-1] : '0;
            sa = (ssp > 1) ? ss[ssp-2] : '0;
            if (!legal(stk_op, sb, ssp) || apply_cnt == fail_at) begin
                sbad = 1'b1;
            end else begin
                ssp -= arity(stk_op);
                if (keeps(stk_op)) begin
                    ss[ssp] = alu(stk_op, sa, sb, stk_in);
                    ssp++;
                end
            end
        end
        stk_valid = !sbad;
        stk_empty = (ssp == 0);
        stk_head  = (ssp > 0) ? ss[ssp-1] : '0;
    end

    // Program image and model results
    logic [3:0]   pm_op  [D];
    logic [W-1:0] pm_imm [D];
    int           m_end, m_issues, m_pc;
    bit           m_done;
    logic [1:0]   m_code;
    logic [W-1:0] m_result = '0;
    logic [3:0]   m_iop  [D];
    logic [W-1:0] m_iimm [D];
    int           first_done;

    task automatic model_run(input int fail_k);
        logic [W-1:0] s [D];
        logic [W-1:0] a, b;
        int sp;
        sp = 0;
        m_issues = 0;
        m_done = 1'b0;
        m_code = 2'd0;
        for (int p = 0; p < D; p++) begin
            m_pc = p;
            if (pm_op[p] == OP_HALT) begin
                m_end = 4 * p + 2;
                if (sp == 0) m_code = 2'd3;
                else begin
                    m_done = 1'b1;
                    m_result = s[sp-1];
                end
                return;
            end
            if (pm_op[p] > OP_POP) begin
                m_end = 4 * p + 2;
                m_code = 2'd1;
                return;
            end
            m_iop[m_issues] = pm_op[p];
            m_iimm[m_issues] = pm_imm[p];
            m_issues++;
            b = (sp > 0) ? s[sp-1] : '0;
            a = (sp > 1) ? s[sp-2] : '0;
            m_end = 4 * p + 4;
            if (!legal(pm_op[p], b, sp) || m_issues == fail_k) begin
                m_code = 2'd2;
                return;
            end
            sp -= arity(pm_op[p]);
            if (keeps(pm_op[p])) begin
                s[sp] = alu(pm_op[p], a, b, pm_imm[p]);
                sp++;
            end
            if (p == D - 1) begin
                m_done = 1'b1;
                m_result = (sp > 0) ? s[sp-1] : '0;
            end
        end
    endtask

    task automatic load(input int a, input logic [3:0] op,
                        input logic [W-1:0] imm);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = a[AW-1:0];
        prog_op = op;
        prog_imm = imm;
        pm_op[a] = op;
        pm_imm[a] = imm;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Leaves the bench at the negedge just after the start edge
    task automatic kick(input int fail_k);
        @(negedge clk);
        clr_tog = !clr_tog;
        fail_at = (fail_k == 0) ? 0 : apply_cnt + fail_k;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int fail_k, input bit wr_busy);
        bit exp_ap;
        bit prev_ap;
        model_run(fail_k);
        kick(fail_k);
        prev_ap = 1'b0;
        first_done = -1;
        for (int e = 0; e <= m_end; e++) begin
            if (e > 0) @(negedge clk);
            prog_we = 1'b0;
            if (wr_busy && e == 3) begin
                prog_we = 1'b1;
                prog_addr = '0;
                prog_op = OP_PUSH;
                prog_imm = 16'd99;
            end
            if (done && first_done < 0) first_done = e;
            chk("apply_gap", 64'(prev_ap & stk_apply), 64'd0);
            prev_ap = stk_apply;
            if (e < m_end) begin
                exp_ap = (e % 4 == 2) && (e / 4 < m_issues);
                chk("busy_run", 64'(busy), 64'd1);
                chk("done_run", 64'(done), 64'd0);
                chk("err_run", 64'(error), 64'd0);
                chk("apply", 64'(stk_apply), 64'(exp_ap));
                chk("stk_op", 64'(stk_op), exp_ap ? 64'(m_iop[e/4]) : 64'd0);
                chk("stk_in", 64'(stk_in), exp_ap ? 64'(m_iimm[e/4]) : 64'd0);
            end else begin
                chk("busy_end", 64'(busy), 64'd0);
                chk("done_end", 64'(done), 64'(m_done));
                chk("err_end", 64'(error), 64'(!m_done));
                chk("err_code", 64'(err_code), 64'(m_code));
                chk("pc_end", 64'(pc), 64'(m_pc));
                chk("result", 64'(result), 64'(m_result));
                chk("apply_end", 64'(stk_apply), 64'd0);
            end
        end
        prog_we = 1'b0;
    endtask

    int base;
    logic [W-1:0] held;

    initial begin
        for (int i = 0; i < D; i++) begin
            pm_op[i] = OP_HALT;
            pm_imm[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_state", 64'({busy, done, error, err_code, pc, result,
                              stk_op, stk_in, stk_apply}), 64'd0);
        rst = 1'b1;

        load(0, OP_PUSH, 16'd7);
        load(1, OP_PUSH, 16'd5);
        load(2, OP_ADD, 16'd0);
        load(3, OP_HALT, 16'd0);
        base = apply_cnt;
        run(0, 1'b0);
        chk("p1_model", 64'(m_result), 64'd12);
        chk("p1_result", 64'(result), 64'd12);
        chk("p1_done_cyc", 64'(first_done), 64'd14);
        chk("p1_applies", 64'(apply_cnt - base), 64'd3);

        load(0, OP_PUSH, 16'd150);
        load(1, OP_PUSH, 16'd2);
        load(2, OP_SUB, 16'd0);
        run(0, 1'b0);
        chk("p2_result", 64'(result), 64'd148);
        chk("p2_pc", 64'(pc), 64'd3);

        load(0, OP_PUSH, 16'd6);
        load(1, OP_PUSH, 16'd7);
        load(2, OP_MUL, 16'd0);
        load(3, OP_DEC, 16'd0);
        load(4, OP_PUSH, 16'd5);
        load(5, OP_MOD, 16'd0);
        load(6, OP_PUSH, 16'd9);
        load(7, OP_POP2, 16'd0);
        load(8, OP_PUSH, 16'd3);
        load(9, OP_POP, 16'd0);
        load(10, OP_PUSH, 16'd8);
        load(11, OP_INC, 16'd0);
        load(12, OP_HALT, 16'd0);
        run(0, 1'b0);
        chk("p6_result", 64'(result), 64'd9);

        load(0, OP_PUSH, 16'd300);
        load(1, 4'd10, 16'd0);
        base = apply_cnt;
        run(0, 1'b0);
        chk("p3_code", 64'(err_code), 64'd1);
        chk("p3_pc", 64'(pc), 64'd1);
        chk("p3_applies", 64'(apply_cnt - base), 64'd1);

        load(0, OP_ADD, 16'd0);
        run(0, 1'b0);
        chk("p4_code", 64'(err_code), 64'd2);
        chk("p4_pc", 64'(pc), 64'd0);

        load(0, OP_PUSH, 16'd4);
        load(1, OP_PUSH, 16'd0);
        load(2, OP_MOD, 16'd0);
        run(0, 1'b0);
        chk("mod0_pc", 64'(pc), 64'd2);

        load(0, OP_PUSH, 16'd1);
        load(1, OP_PUSH, 16'd2);
        load(2, OP_ADD, 16'd0);
        load(3, OP_HALT, 16'd0);
        run(2, 1'b0);
        chk("forced_code", 64'(err_code), 64'd2);
        chk("forced_pc", 64'(pc), 64'd1);

        load(0, OP_HALT, 16'd0);
        run(0, 1'b0);
        chk("p5_code", 64'(err_code), 64'd3);

        load(0, OP_PUSH, 16'd1);
        for (int i = 1; i < D; i++) load(i, OP_INC, 16'd0);
        run(0, 1'b0);
        chk("eom_result", 64'(result), 64'd16);
        chk("eom_pc", 64'(pc), 64'd15);
        chk("eom_done_cyc", 64'(first_done), 64'd64);

        // abort during the second instruction's issue cycle
        held = result;
        kick(0);
        repeat (6) @(negedge clk);
        chk("pre_abort_apply", 64'(stk_apply), 64'd1);
        abort = 1'b1;
        #1;
        chk("abort_gate", 64'(stk_apply), 64'd0);
        base = apply_cnt;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_flags", 64'({done, error}), 64'd0);
        chk("abort_result", 64'(result), 64'(held));
        repeat (8) @(negedge clk);
        chk("abort_applies", 64'(apply_cnt - base), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", 64'(busy), 64'd0);
        @(negedge clk);
        chk("start_abort2", 64'(busy), 64'd0);

        load(0, OP_PUSH, 16'd1);
        load(1, OP_PUSH, 16'd2);
        load(2, OP_ADD, 16'd0);
        load(3, OP_HALT, 16'd0);
        run(0, 1'b1);
        run(0, 1'b0);
        chk("drop_write", 64'(result), 64'd3);

        // asynchronous reset in the middle of an issue cycle
        kick(0);
        repeat (6) @(negedge clk);
        chk("pre_rst_apply", 64'(stk_apply), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst", 64'({busy, done, error, err_code, pc, result,
                              stk_op, stk_in, stk_apply}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        m_result = '0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
